hex_scan_mux: RTL
=================

Name: hex_scan_mux

Overview:
- Downstream display stage for the signed add/subtract datapath.
- Takes the four 7-segment patterns HEX3..HEX0 (hundreds, tens, ones, sign) and time-multiplexes them onto one shared segment bus with per-digit anode enables. This suits boards with a common-segment 4-digit display.
- Latches a frame snapshot so each digit shows a consistent value for the whole scan frame.
- Inserts a ghosting guard (blank interval) at the start of every digit slot.

Parameters:
- DIV, 50000, clock cycles per digit slot. Legal range 2..2^20.
- BLANK, 500, cycles at the start of each slot with all anodes off. Legal range 1 <= BLANK < DIV.
- AN_ACTIVE_LOW, 1, 1 means an[] is active-low; 0 means active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable. When 0, the scan freezes and the display is dark.
- HEX3  in  7  segment pattern for digit 3 (hundreds). Active-low segments, bit order g..a.
- HEX2  in  7  segment pattern for digit 2 (tens).
- HEX1  in  7  segment pattern for digit 1 (ones).
- HEX0  in  7  segment pattern for digit 0 (sign).
- seg  out  7  shared segment bus. Active-low, passed through unchanged from the snapshot.
- an  out  4  digit enables. an[k] selects digit k. Polarity is set by AN_ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse marking a snapshot load.

Behaviour:
- Reset state (asynchronous, while rst=1):
  - cnt=0, idx=0.
  - snap[3:0]=7'h7F.
  - seg=7'h7F, an=AN_OFF (4'hF if AN_ACTIVE_LOW, else 4'h0).
  - frame_tick=0.
- Reset mid-frame: everything returns to the reset state immediately. The first frame after release starts at slot 0.
- Slot counter:
  - When en=1, cnt increments each cycle.
  - When cnt==DIV-1, cnt wraps to 0 and idx advances 0->1->2->3->0 (2-bit wrap).
- Snapshot load:
  - Occurs in any cycle with en=1, cnt==0 and idx==0. This includes the first enabled cycle after reset.
  - snap[k] <= HEXk sampled in that cycle.
  - frame_tick is registered high in the following cycle only.
- Input changes outside the load cycle have no effect until the next frame.
- Output generation (registered, one-cycle latency from the cnt/idx/snap state):
  - If en=0: seg=7'h7F, an=AN_OFF.
  - Else if cnt<BLANK: seg=7'h7F, an=AN_OFF (guard interval).
  - Else: seg=snap[idx], and an has only bit idx asserted.
  - BLANK>=1 guarantees a freshly loaded snapshot is never driven in its own load cycle.
- Enable behaviour:
  - en=0 holds cnt and idx. No load occurs and frame_tick stays 0.
  - When en returns to 1, the scan resumes from the held cnt/idx. If held at cnt=0, idx=0, exactly one load occurs.
- Anode exclusivity: at most one anode is asserted in any cycle. When idx changes, the output is always dark because the new slot starts inside its guard interval.
- Frame period is 4*DIV cycles. frame_tick fires once per frame.
- cnt width is clog2(DIV).
- Parameter guard: an elaboration-time check fails if BLANK>=DIV or BLANK<1.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_OFF=7'h7F.
  - Glyph constants SEG_MINUS=7'h3F and SEG_ZERO=7'h40 (used by the bench).
  - The digit-index typedef (2-bit).
  - The AN_OFF function of AN_ACTIVE_LOW.
- One sub-module, scan_slot_timer, owns cnt/idx, the wrap logic and the load/blank strobes. The top level owns snap, the output mux and the output registers.

Test Plan (DIV=8, BLANK=2, AN_ACTIVE_LOW=1):
- Reset assertion:
  - Stimulus: assert rst asynchronously mid-slot (idx=2, cnt=5).
  - Required response: seg=7'h7F and an=4'hF with no clock edge needed. After release, the first load occurs on the first enabled edge and frame_tick pulses one cycle later.
- Basic scan:
  - Stimulus: HEX3=7'h79, HEX2=7'h24, HEX1=7'h30, HEX0=7'h3F, en=1.
  - Required response: each slot is dark for 2 cycles, then shows 6 cycles of the digit. Sequence: an=4'hE/seg=7'h3F, an=4'hD/7'h30, an=4'hB/7'h24, an=4'h7/7'h79. Period 32 cycles, with one frame_tick per 32 cycles.
- Snapshot isolation:
  - Stimulus: change HEX1 to 7'h02 while idx=2.
  - Required response: seg during slot 1 stays 7'h30 for the current frame and shows 7'h02 in the next frame.
- Enable freeze:
  - Stimulus: drop en for 10 cycles at idx=1, cnt=4, then re-raise it.
  - Required response: output is dark while en is low. On resume, slot 1 completes its remaining cycles with no extra frame_tick.
- Exclusivity:
  - Stimulus: random HEX inputs and random en over 10k cycles.
  - Required response: the bench asserts that an has at most one zero bit in every cycle, and that an==4'hF whenever cnt<BLANK.
- Sign path:
  - Stimulus: HEX0=SEG_MINUS vs. HEX0=7'h7F (blank).
  - Required response: slot 0 shows 7'h3F or is fully dark respectively, with an[0] still asserted.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, digit index type and anode polarity helpers.
package seg7_pkg;

  // Segment patterns are active-low, bit order g..a.
  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  typedef logic [1:0] digit_idx_t;

  // All anodes deasserted for the selected polarity.
  function automatic logic [3:0] an_off(input bit active_low);
    return active_low ? 4'hF : 4'h0;
  endfunction

  // Only anode idx asserted for the selected polarity.
  function automatic logic [3:0] an_sel(input digit_idx_t idx, input bit active_low);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/hex_scan_mux_if.sv
// Digit inputs and multiplexed display outputs of the scan mux.
interface hex_scan_mux_if;
  import seg7_pkg::*;

  logic       en;
  logic [6:0] HEX3;
  logic [6:0] HEX2;
  logic [6:0] HEX1;
  logic [6:0] HEX0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output en, HEX3, HEX2, HEX1, HEX0,
    input  seg, an, frame_tick
  );

  modport slave (
    input  en, HEX3, HEX2, HEX1, HEX0,
    output seg, an, frame_tick
  );

endinterface

// File: rtl/scan_slot_timer.sv
// Digit slot timer: cycle counter within a slot, digit index, and the
// snapshot-load and guard-interval strobes decoded from that state.
module scan_slot_timer
  import seg7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output digit_idx_t idx_o,
  output logic       load_o,
  output logic       blank_o
);

  localparam int               CNT_W     = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

  if (DIV < 2 || DIV > (1 << 20)) begin : g_bad_div
    $error("scan_slot_timer: DIV must be in 2..2^20");
  end

  if (BLANK < 1 || BLANK >= DIV) begin : g_bad_blank
    $error("scan_slot_timer: BLANK must satisfy 1 <= BLANK < DIV");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;

  // Advance the slot counter while enabled; wrap and step the digit index.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (en_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Slot counter and digit index state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o   = idx_q;
  assign load_o  = en_i && (cnt_q == '0) && (idx_q == 2'd0);
  assign blank_o = (cnt_q < CNT_BLANK);

endmodule

// File: rtl/hex_scan_mux.sv
// Time-multiplexes four 7-segment patterns onto one segment bus with
// per-digit anode enables, a per-frame input snapshot and a blank guard
// at the start of each digit slot.
module hex_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIV           = 50000,
  parameter int BLANK         = 500,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input logic           clk,
  input logic           rst,
  hex_scan_mux_if.slave bus
);

  localparam logic [3:0] AN_OFF = an_off(AN_ACTIVE_LOW);

  digit_idx_t idx;
  logic       load;
  logic       blank;

  logic [6:0] snap_q [4];
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic       tick_q;

  scan_slot_timer #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en_i    (bus.en),
    .idx_o   (idx),
    .load_o  (load),
    .blank_o (blank)
  );

  // Capture all four digits together once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) snap_q[k] <= SEG_OFF;
    end else if (load) begin
      snap_q[0] <= bus.HEX0;
      snap_q[1] <= bus.HEX1;
      snap_q[2] <= bus.HEX2;
      snap_q[3] <= bus.HEX3;
    end
  end

  // Dark while disabled or inside the guard interval, else drive the digit.
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if (bus.en && !blank) begin
      seg_d = snap_q[idx];
      an_d  = an_sel(idx, AN_ACTIVE_LOW);
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= load;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule
